// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: PRGA state encoding, header sizing helper and S memory depth.
package arc4_pkg;
  localparam int S_DEPTH = 256;

  typedef enum logic [3:0] {
    IDLE, HDR, RD_I, RD_J, WR_J, WR_I, RD_K, OUT, DONE
  } prga_state_t;

  function automatic int hdr_bytes(input int aw);
    return (aw + 7) / 8;
  endfunction
endpackage

// File: rtl/prga_stream_if.sv
// Handshake plus S / ciphertext / plaintext memory buses of the PRGA stage.
interface prga_stream_if import arc4_pkg::*; #(parameter int MSG_AW = 8) ();
  logic                         en;
  logic                         rdy;
  logic                         mode;
  logic                         done;
  logic [$clog2(S_DEPTH)-1:0]   s_addr;
  logic [7:0]                   s_rddata;
  logic [7:0]                   s_wrdata;
  logic                         s_wren;
  logic [MSG_AW-1:0]            ct_addr;
  logic [7:0]                   ct_rddata;
  logic [MSG_AW-1:0]            pt_addr;
  logic [7:0]                   pt_wrdata;
  logic                         pt_wren;

  modport slave (
    input  en, mode, s_rddata, ct_rddata,
    output rdy, done, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
  modport master (
    output en, mode, s_rddata, ct_rddata,
    input  rdy, done, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/arc4_hdr_copy.sv
// Header pipeline: reads ct[0..HDR_B-1], copies each byte to pt one cycle later,
// and assembles the little-endian payload length (clamped to the buffer size).
module arc4_hdr_copy import arc4_pkg::*; #(
  parameter int MSG_AW = 8,
  parameter int HDR_B  = hdr_bytes(MSG_AW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic [7:0]        ct_rddata,
  output logic [MSG_AW-1:0] ct_addr,
  output logic [MSG_AW-1:0] pt_addr,
  output logic [7:0]        pt_wrdata,
  output logic              pt_wren,
  output logic              last,
  output logic [MSG_AW-1:0] len,
  output logic [MSG_AW-1:0] len_now
);
  localparam int          RAW_W   = 8 * HDR_B;
  localparam logic [31:0] MAX_LEN = 32'((64'd1 << MSG_AW) - 64'(HDR_B));

  logic [7:0]       h_reg;
  logic [RAW_W-1:0] raw_reg;
  logic [RAW_W-1:0] raw_next;

  function automatic logic [MSG_AW-1:0] clamp(input logic [RAW_W-1:0] raw);
    logic [63:0] r;
    r = 64'(raw);
    return (r > 64'(MAX_LEN)) ? MSG_AW'(MAX_LEN) : MSG_AW'(r);
  endfunction

  assign pt_wren   = active && (h_reg != 8'd0);
  assign last      = active && (h_reg == 8'(HDR_B));
  assign ct_addr   = MSG_AW'(h_reg);
  assign pt_addr   = pt_wren ? MSG_AW'(h_reg - 8'd1) : '0;
  assign pt_wrdata = pt_wren ? ct_rddata : 8'd0;

  // Byte h-1 arrives in the cycle after its address was issued.
  for (genvar gi = 0; gi < HDR_B; gi++) begin : g_byte
    assign raw_next[gi*8 +: 8] = (pt_wren && h_reg == 8'(gi + 1)) ? ct_rddata : raw_reg[gi*8 +: 8];
  end

  assign len     = clamp(raw_reg);
  assign len_now = clamp(raw_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg   <= 8'd0;
      raw_reg <= '0;
    end else begin
      h_reg   <= active ? h_reg + 8'd1 : 8'd0;
      raw_reg <= raw_next;
    end
  end
endmodule

// File: rtl/prga_stream.sv
// ARC4 PRGA stage over the shared S memory: header copy, optional keystream drop,
// then one 6-cycle step per payload byte producing ct^pad (or pad alone).
module prga_stream import arc4_pkg::*; #(
  parameter int MSG_AW = 8,
  parameter int DROP_N = 0,
  parameter int HDR_B  = hdr_bytes(MSG_AW)
) (
  input logic          clk,
  input logic          rst,
  prga_stream_if.slave bus
);
  localparam logic [MSG_AW-1:0] BASE = MSG_AW'(HDR_B);

  prga_state_t       state_reg;
  logic [7:0]        i_reg, j_reg, si_reg, sj_reg, ctb_reg;
  logic [MSG_AW-1:0] k_reg;
  logic [15:0]       drop_reg;
  logic              mode_reg, rdy_reg, done_reg;

  logic [MSG_AW-1:0] hdr_ct_addr, hdr_pt_addr, len, len_now;
  logic [7:0]        hdr_pt_wrdata, j_sum;
  logic              hdr_pt_wren, hdr_last, step_last;

  arc4_hdr_copy #(.MSG_AW(MSG_AW), .HDR_B(HDR_B)) u_hdr (
    .clk       (clk),
    .rst       (rst),
    .active    (state_reg == HDR),
    .ct_rddata (bus.ct_rddata),
    .ct_addr   (hdr_ct_addr),
    .pt_addr   (hdr_pt_addr),
    .pt_wrdata (hdr_pt_wrdata),
    .pt_wren   (hdr_pt_wren),
    .last      (hdr_last),
    .len       (len),
    .len_now   (len_now)
  );

  assign j_sum     = j_reg + bus.s_rddata;
  assign step_last = (drop_reg != 16'd0) ? (drop_reg == 16'd1 && len == '0)
                                         : ((k_reg + MSG_AW'(1)) == len);
  assign bus.rdy   = rdy_reg | rst;
  assign bus.done  = done_reg & ~rst;

  // Memory-side outputs decode the current state; reset forces them idle at once.
  always_comb begin
    bus.s_addr    = 8'd0;
    bus.s_wrdata  = 8'd0;
    bus.s_wren    = 1'b0;
    bus.ct_addr   = '0;
    bus.pt_addr   = '0;
    bus.pt_wrdata = 8'd0;
    bus.pt_wren   = 1'b0;
    if (!rst) begin
      case (state_reg)
        HDR: begin
          bus.ct_addr   = hdr_ct_addr;
          bus.pt_addr   = hdr_pt_addr;
          bus.pt_wrdata = hdr_pt_wrdata;
          bus.pt_wren   = hdr_pt_wren;
        end
        RD_I: begin
          bus.s_addr  = i_reg;
          bus.ct_addr = BASE + k_reg;
        end
        RD_J: bus.s_addr = j_sum;
        WR_J: begin
          bus.s_addr   = j_reg;
          bus.s_wrdata = si_reg;
          bus.s_wren   = 1'b1;
        end
        WR_I: begin
          bus.s_addr   = i_reg;
          bus.s_wrdata = sj_reg;
          bus.s_wren   = 1'b1;
        end
        RD_K: bus.s_addr = si_reg + sj_reg;
        OUT: begin
          if (drop_reg == 16'd0) begin
            bus.pt_addr   = BASE + k_reg;
            bus.pt_wrdata = mode_reg ? bus.s_rddata : (ctb_reg ^ bus.s_rddata);
            bus.pt_wren   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      rdy_reg   <= 1'b1;
      done_reg  <= 1'b0;
      mode_reg  <= 1'b0;
      i_reg     <= 8'd1;
      j_reg     <= 8'd0;
      k_reg     <= '0;
      si_reg    <= 8'd0;
      sj_reg    <= 8'd0;
      ctb_reg   <= 8'd0;
      drop_reg  <= 16'd0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.en) begin
            mode_reg  <= bus.mode;
            rdy_reg   <= 1'b0;
            i_reg     <= 8'd1;
            j_reg     <= 8'd0;
            k_reg     <= '0;
            drop_reg  <= 16'(DROP_N);
            state_reg <= HDR;
          end
        end
        HDR: begin
          if (hdr_last) begin
            if (DROP_N == 0 && len_now == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RD_I;
            end
          end
        end
        RD_I: state_reg <= RD_J;
        RD_J: begin
          si_reg    <= bus.s_rddata;
          ctb_reg   <= bus.ct_rddata;
          j_reg     <= j_sum;
          state_reg <= WR_J;
        end
        WR_J: begin
          sj_reg    <= bus.s_rddata;
          state_reg <= WR_I;
        end
        WR_I: state_reg <= RD_K;
        RD_K: state_reg <= OUT;
        OUT: begin
          i_reg <= i_reg + 8'd1;
          if (drop_reg != 16'd0) drop_reg <= drop_reg - 16'd1;
          else                   k_reg    <= k_reg + MSG_AW'(1);
          state_reg <= step_last ? DONE : RD_I;
          done_reg  <= step_last;
        end
        DONE: begin
          rdy_reg   <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
